// File: rtl/i2c_arb_pkg.sv
// rtl/i2c_arb_pkg.sv - shared types and constants for the I2C master arbiter
package i2c_arb_pkg;

  localparam int TO_W         = 16;
  localparam int NREQ_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // One-hot decode of a requester index; callers truncate to their width.
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational round-robin winner selection
module rr_select #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [2:0]   last_i,
  output logic [2:0]   winner_o,
  output logic         valid_o
);

  logic [7:0] req_pad;
  logic [2:0] idx;

  // Scan from farthest to nearest offset so the requester just after last_i wins.
  always_comb begin
    req_pad          = '0;
    req_pad[N-1:0]   = req_i;
    winner_o         = '0;
    valid_o          = 1'b0;
    idx              = '0;
    for (int i = N; i >= 1; i--) begin
      idx = 3'((int'(last_i) + i) % N);
      if (req_pad[idx]) begin
        winner_o = idx;
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// rtl/i2c_master_arbiter.sv - round-robin arbiter in front of a single I2C master
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int              NREQ    = NREQ_DEFAULT,
  parameter logic [TO_W-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_rw,
  output logic [NREQ-1:0]   req_accept,
  output logic [NREQ-1:0]   req_done,
  output logic              rsp_err,
  output logic [7:0]        rsp_data,
  output logic [6:0]        m_addr,
  output logic [7:0]        m_data,
  output logic              m_rw,
  output logic              m_enable,
  input  logic              m_ready,
  input  logic [7:0]        m_data_out,
  output logic              busy,
  output logic [2:0]        grant_id
);

  state_t            state_q, state_d;
  logic [2:0]        grant_q, grant_d;
  logic [6:0]        addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              rw_q, rw_d;
  logic              en_q, en_d;
  logic [NREQ-1:0]   acc_q, acc_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [TO_W-1:0]   tmo_q, tmo_d, tmo_inc;
  logic [2:0]        win;
  logic              win_valid;

  // Requester fields padded to 8 entries so a 3-bit grant indexes them directly.
  logic [6:0] addr_arr [8];
  logic [7:0] data_arr [8];
  logic [7:0] rw_pad;

  for (genvar g = 0; g < 8; g++) begin : g_slice
    if (g < NREQ) begin : g_used
      assign addr_arr[g] = req_addr[7*g +: 7];
      assign data_arr[g] = req_data[8*g +: 8];
      assign rw_pad[g]   = req_rw[g];
    end else begin : g_pad
      assign addr_arr[g] = '0;
      assign data_arr[g] = '0;
      assign rw_pad[g]   = 1'b0;
    end
  end

  rr_select #(.N(NREQ)) u_rr (
    .req_i    (req_valid),
    .last_i   (grant_q),
    .winner_o (win),
    .valid_o  (win_valid)
  );

  // Handshake counter saturates so a huge TIMEOUT can never wrap back to zero.
  assign tmo_inc = (tmo_q == '1) ? tmo_q : tmo_q + 16'd1;

  // Next-state and registered-output decisions for the handshake FSM.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rw_d    = rw_q;
    en_d    = en_q;
    acc_d   = '0;
    done_d  = '0;
    err_d   = err_q;
    rdata_d = rdata_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (m_ready && win_valid) begin
          addr_d  = addr_arr[win];
          data_d  = data_arr[win];
          rw_d    = rw_pad[win];
          acc_d   = NREQ'(onehot8(win));
          grant_d = win;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        en_d    = 1'b1;
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        tmo_d = tmo_inc;
        if (!m_ready) begin
          en_d    = 1'b0;
          state_d = WAIT_DONE;
        end else if (tmo_inc >= TIMEOUT) begin
          en_d    = 1'b0;
          done_d  = NREQ'(onehot8(grant_q));
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        tmo_d = tmo_inc;
        if (m_ready) begin
          done_d  = NREQ'(onehot8(grant_q));
          err_d   = 1'b0;
          rdata_d = m_data_out;
          state_d = IDLE;
        end else if (tmo_inc >= TIMEOUT) begin
          en_d    = 1'b0;
          done_d  = NREQ'(onehot8(grant_q));
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 3'(NREQ - 1);
      addr_q  <= '0;
      data_q  <= '0;
      rw_q    <= 1'b0;
      en_q    <= 1'b0;
      acc_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rw_q    <= rw_d;
      en_q    <= en_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      tmo_q   <= tmo_d;
    end
  end

  assign req_accept = acc_q;
  assign req_done   = done_q;
  assign rsp_err    = err_q;
  assign rsp_data   = rdata_q;
  assign m_addr     = addr_q;
  assign m_data     = data_q;
  assign m_rw       = rw_q;
  assign m_enable   = en_q;
  assign busy       = (state_q != IDLE);
  assign grant_id   = grant_q;

endmodule

// File: doc/i2c_master_arbiter.md
I2C_MASTER_ARBITER -- requirements
Module: i2c_master_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 16'hFFFF, clk cycles allowed per handshake phase before abort.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, NREQ, per-requester transaction request, held until accepted.
REQ-006 SHALL have port req_addr, input, 7*NREQ, packed 7-bit slave addresses, slice i belongs to requester i.
REQ-007 SHALL have port req_data, input, 8*NREQ, packed write bytes.
REQ-008 SHALL have port req_rw, input, NREQ, per-requester rd_wr bit (1 = read).
REQ-009 SHALL have port req_accept, output, NREQ, one-hot one-cycle pulse: request latched.
REQ-010 SHALL have port req_done, output, NREQ, one-hot one-cycle pulse: transaction finished.
REQ-011 SHALL have port rsp_err, output, 1, valid with req_done: 1 = timeout abort.
REQ-012 SHALL have port rsp_data, output, 8, valid with req_done: master data_out captured at completion.
REQ-013 SHALL have ports m_addr (output, 7), m_data (output, 8), m_rw (output, 1), m_enable (output, 1) driving the I2C master addr_top, data_in_top, rd_wr, enable.
REQ-014 SHALL have ports m_ready (input, 1) and m_data_out (input, 8) from the I2C master ready and data_out.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE; grant_id, output, 3, index of current/last winner.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-017 IDLE: when m_ready=1 and any req_valid=1, SHALL select winner round-robin starting at grant_id+1 (mod NREQ), latch its addr/data/rw into m_addr/m_data/m_rw, pulse req_accept[winner], set grant_id, go ISSUE.
REQ-018 IDLE with m_ready=0 SHALL accept nothing; requests wait.
REQ-019 ISSUE: SHALL assert m_enable, clear timeout counter, go WAIT_BUSY next cycle.
REQ-020 WAIT_BUSY: SHALL hold m_enable=1 and m_addr/m_data/m_rw stable until m_ready=0 (master is clock-enable paced), then drop m_enable and go WAIT_DONE.
REQ-021 WAIT_DONE: on m_ready=1 SHALL pulse req_done[grant_id], rsp_data=m_data_out, rsp_err=0, go IDLE.
REQ-022 Timeout counter (16-bit, saturating) SHALL count every cycle in WAIT_BUSY/WAIT_DONE; on reaching TIMEOUT SHALL drop m_enable, pulse req_done[grant_id] with rsp_err=1, rsp_data=0, go IDLE.
REQ-023 Latency: req_valid seen in IDLE -> req_accept same-edge registered (1 cycle); m_enable rises the cycle after req_accept.
REQ-024 req_valid of the active requester changing after accept SHALL not affect the transaction.
REQ-025 Simultaneous requests SHALL be served in rotation; no requester waits more than NREQ-1 grants.
REQ-026 req_accept and req_done SHALL never be asserted in the same cycle; at most one bit of each set.
REQ-027 Outputs not named otherwise SHALL be registered; no combinational path from req_* to m_*.

Reset
REQ-028 rst SHALL force IDLE, m_enable=0, m_addr=0, m_data=0, m_rw=0, req_accept=0, req_done=0, rsp_err=0, rsp_data=0, busy=0, timeout=0 immediately.
REQ-029 grant_id SHALL reset to NREQ-1 so requester 0 wins first.
REQ-030 Reset mid-transaction SHALL issue no req_done for the aborted request.

Structure
REQ-031 Package i2c_arb_pkg SHALL hold the state encoding, TIMEOUT width constant (16) and default NREQ.
REQ-032 Round-robin selection SHALL be one combinational sub-module rr_select (req vector, last grant -> winner, valid).

Verification
REQ-033 Single: req_valid[2]=1, addr 7'h50, data 8'hA5, rw 0, m_ready model drops after 3 cycles, returns after 40 -> req_accept[2], m_addr=50/m_data=A5, req_done[2], rsp_err=0.
REQ-034 Contention: req_valid=4'b1111 held, after reset -> grant order 0,1,2,3,0.
REQ-035 Read: req_rw[1]=1, master returns m_data_out=8'h3C -> req_done[1] with rsp_data=8'h3C.
REQ-036 Timeout: TIMEOUT=16, m_ready stays 1 (never busy) -> m_enable held 16 cycles, then req_done with rsp_err=1, m_enable=0.
REQ-037 Reset in WAIT_DONE -> all outputs at reset values next edge, no req_done; next request goes to requester 0.
REQ-038 m_ready=0 in IDLE with req_valid=1 -> no req_accept until m_ready=1.
